// File: rtl/perf_pkg.sv
// Shared types for the pipeline performance monitor.
// Control/readout state encodings and readout index sizing.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } ctl_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_e;

  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with a sticky overflow flag.
// Holds at all-ones; ovf marks the first blocked increment.
module perf_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ovf
);

  // Count up, hold at all-ones, latch overflow until cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&count) begin
        ovf <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: cycle + event counters, snapshot stream.
// Optional PERF_EVENT_QUAL_EN adds event_inhibit_i to mask events.
module pipe_perf_monitor
  import perf_pkg::*;
#(
  parameter int              NUM_EVENTS  = 4,
  parameter int              CNT_WIDTH   = 32,
  parameter longint unsigned CYCLE_LIMIT = 0,
  parameter int              IDX_W       = idx_w(NUM_EVENTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  clear_i,
  input  logic [NUM_EVENTS-1:0] event_i,
`ifdef PERF_EVENT_QUAL_EN
  input  logic [NUM_EVENTS-1:0] event_inhibit_i,
`endif
  input  logic                  snap_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic [IDX_W-1:0]      rd_idx_o,
  output logic                  rd_last_o,
  output logic                  running_o,
  output logic                  done_o,
  output logic [NUM_EVENTS:0]   ovf_o
);

  ctl_state_e state;
  rd_state_e  rd_state;

  logic [NUM_EVENTS-1:0] ev_q;
  logic [NUM_EVENTS:0]   inc;
  logic [NUM_EVENTS:0]   ovf;
  logic [CNT_WIDTH-1:0]  cnt    [NUM_EVENTS+1];
  logic [CNT_WIDTH-1:0]  shadow [NUM_EVENTS+1];
  logic                  lim_hit;

`ifdef PERF_EVENT_QUAL_EN
  assign ev_q = event_i & ~event_inhibit_i;
`else
  assign ev_q = event_i;
`endif

  // Slot 0 tallies RUN cycles; slot k+1 tallies event k.
  assign inc[0] = (state == RUN);
  assign inc[NUM_EVENTS:1] = (state == RUN) ? ev_q : '0;

  for (genvar i = 0; i <= NUM_EVENTS; i++) begin : g_cnt
    perf_sat_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .clear(clear_i),
      .inc  (inc[i]),
      .count(cnt[i]),
      .ovf  (ovf[i])
    );
  end

  assign ovf_o = ovf;

  // Stop on the edge the cycle count reaches the limit.
  if (CYCLE_LIMIT > 0) begin : g_lim
    localparam logic [CNT_WIDTH-1:0] LIM_M1 =
      CNT_WIDTH'(CYCLE_LIMIT - 64'd1);
    assign lim_hit = (cnt[0] >= LIM_M1);
  end else begin : g_nolim
    assign lim_hit = 1'b0;
  end

  // Control FSM; stop beats start, clear beats both.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state     <= IDLE;
      running_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !stop_i) begin
            state     <= RUN;
            running_o <= 1'b1;
          end
        end
        RUN: begin
          if (stop_i || lim_hit) begin
            state     <= STOP;
            running_o <= 1'b0;
            done_o    <= 1'b1;
          end
        end
        STOP: begin
          if (start_i && !stop_i) begin
            state     <= RUN;
            running_o <= 1'b1;
            done_o    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          running_o <= 1'b0;
          done_o    <= 1'b0;
        end
      endcase
    end
  end

  // Readout FSM; shadows decouple the stream from live counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state   <= RD_IDLE;
      rd_valid_o <= 1'b0;
      rd_idx_o   <= '0;
      rd_last_o  <= 1'b0;
      for (int i = 0; i <= NUM_EVENTS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (snap_i) begin
            for (int i = 0; i <= NUM_EVENTS; i++) begin
              shadow[i] <= cnt[i];
            end
            rd_state   <= RD_STREAM;
            rd_valid_o <= 1'b1;
            rd_idx_o   <= '0;
            rd_last_o  <= 1'b0;
          end
        end
        RD_STREAM: begin
          if (rd_ready_i) begin
            if (rd_last_o) begin
              rd_state   <= RD_IDLE;
              rd_valid_o <= 1'b0;
              rd_idx_o   <= '0;
              rd_last_o  <= 1'b0;
            end else begin
              rd_idx_o  <= rd_idx_o + 1'b1;
              rd_last_o <= (rd_idx_o == IDX_W'(NUM_EVENTS - 1));
            end
          end
        end
        default: begin
          rd_state   <= RD_IDLE;
          rd_valid_o <= 1'b0;
          rd_idx_o   <= '0;
          rd_last_o  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data_o = rd_valid_o ? shadow[rd_idx_o] : '0;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Scoreboard bench for pipe_perf_monitor.
// Three instances: base, cycle limit 30, 4-bit counters.
module tb_pipe_perf_monitor;

  typedef struct {
    int              idx;
    longint unsigned data;
    bit              last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst, start, stop, clear, rd_ready;
  logic [1:0] ev;
  logic       snap_a, snap_b, snap_c;

  logic       va, vb, vc;
  logic [7:0] da, db;
  logic [3:0] dc;
  logic [1:0] ia, ib, ic;
  logic       la, lb, lc;
  logic       ra, rb, rc;
  logic       dna, dnb, dnc;
  logic [2:0] oa, ob, oc;

  beat_t qa[$], qb[$], qc[$];
  beat_t ea, eb, ec;
  int    total = 0;
  int    bad   = 0;
  int    hs_a  = 0;

  always #5 clk = ~clk;

  pipe_perf_monitor #(
    .NUM_EVENTS(2), .CNT_WIDTH(8), .CYCLE_LIMIT(0)
  ) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .clear_i(clear), .event_i(ev),
`ifdef PERF_EVENT_QUAL_EN
    .event_inhibit_i(2'b00),
`endif
    .snap_i(snap_a), .rd_valid_o(va), .rd_ready_i(rd_ready),
    .rd_data_o(da), .rd_idx_o(ia), .rd_last_o(la),
    .running_o(ra), .done_o(dna), .ovf_o(oa)
  );

  pipe_perf_monitor #(
    .NUM_EVENTS(2), .CNT_WIDTH(8), .CYCLE_LIMIT(30)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .clear_i(clear), .event_i(ev),
`ifdef PERF_EVENT_QUAL_EN
    .event_inhibit_i(2'b00),
`endif
    .snap_i(snap_b), .rd_valid_o(vb), .rd_ready_i(rd_ready),
    .rd_data_o(db), .rd_idx_o(ib), .rd_last_o(lb),
    .running_o(rb), .done_o(dnb), .ovf_o(ob)
  );

  pipe_perf_monitor #(
    .NUM_EVENTS(2), .CNT_WIDTH(4), .CYCLE_LIMIT(0)
  ) u_c (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .clear_i(clear), .event_i(ev),
`ifdef PERF_EVENT_QUAL_EN
    .event_inhibit_i(2'b00),
`endif
    .snap_i(snap_c), .rd_valid_o(vc), .rd_ready_i(rd_ready),
    .rd_data_o(dc), .rd_idx_o(ic), .rd_last_o(lc),
    .running_o(rc), .done_o(dnc), .ovf_o(oc)
  );

  task automatic chk(input string nm, input longint unsigned act,
                     input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm, input int idx);
    total++;
    bad++;
    $display("FAIL %s got=beat idx %0d want=no beat", nm, idx);
  endtask

  always @(negedge clk) begin
    if (!rst && va && rd_ready) begin
      hs_a++;
      if (qa.size() == 0) unexp("a_beat", int'(ia));
      else begin
        ea = qa.pop_front();
        chk("a_idx", ia, ea.idx);
        chk("a_data", da, ea.data);
        chk("a_last", la, ea.last);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && vb && rd_ready) begin
      if (qb.size() == 0) unexp("b_beat", int'(ib));
      else begin
        eb = qb.pop_front();
        chk("b_idx", ib, eb.idx);
        chk("b_data", db, eb.data);
        chk("b_last", lb, eb.last);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && vc && rd_ready) begin
      if (qc.size() == 0) unexp("c_beat", int'(ic));
      else begin
        ec = qc.pop_front();
        chk("c_idx", ic, ec.idx);
        chk("c_data", dc, ec.data);
        chk("c_last", lc, ec.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push3(input int w, input longint unsigned d0,
                       input longint unsigned d1,
                       input longint unsigned d2);
    beat_t b[3];
    b[0] = '{0, d0, 1'b0};
    b[1] = '{1, d1, 1'b0};
    b[2] = '{2, d2, 1'b1};
    for (int i = 0; i < 3; i++) begin
      if (w == 0) qa.push_back(b[i]);
      else if (w == 1) qb.push_back(b[i]);
      else qc.push_back(b[i]);
    end
  endtask

  function automatic int qsize(input int w);
    if (w == 0) return qa.size();
    if (w == 1) return qb.size();
    return qc.size();
  endfunction

  task automatic wait_q(input int w);
    int n = 0;
    while (qsize(w) > 0 && n < 40) begin
      tick();
      n++;
    end
    if (qsize(w) > 0) begin
      total++;
      bad++;
      $display("FAIL q%0d_drain got=%0d left want=0", w, qsize(w));
    end
  endtask

  task automatic snap_read(input int w);
    rd_ready = 1'b1;
    if (w == 0) snap_a = 1'b1;
    else if (w == 1) snap_b = 1'b1;
    else snap_c = 1'b1;
    tick();
    snap_a = 1'b0;
    snap_b = 1'b0;
    snap_c = 1'b0;
    wait_q(w);
  endtask

  initial begin
    int n;
    int hs0;
    longint unsigned exd[3];
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    rd_ready = 1'b0; ev = 2'b00;
    snap_a = 1'b0; snap_b = 1'b0; snap_c = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_valid", va, 0);
    chk("rst_run", ra, 0);
    chk("rst_done", dna, 0);
    chk("rst_ovf", oa, 0);
    chk("rst_data", da, 0);
    chk("rst_idx", ia, 0);
    chk("rst_last", la, 0);

    // basic count then snapshot
    start = 1'b1; tick(); start = 1'b0;
    chk("s1_run", ra, 1);
    for (int i = 0; i < 13; i++) begin
      ev = (i < 10) ? 2'b01 : 2'b10;
      stop = (i == 12);
      tick();
    end
    ev = 2'b00; stop = 1'b0;
    chk("s1_done", dna, 1);
    chk("s1_run_off", ra, 0);
    push3(0, 13, 10, 3);
    snap_read(0);
    chk("s1_valid_off", va, 0);

    // cycle limit
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (rb && n < 50) begin
      n++;
      tick();
    end
    chk("s2_run_cycles", n, 30);
    chk("s2_done", dnb, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("s2_done_hold", dnb, 1);
    chk("s2_run_hold", rb, 0);
    push3(1, 30, 0, 0);
    snap_read(1);
    start = 1'b1; tick(); start = 1'b0;
    chk("s2_rerun", rb, 1);
    tick();
    chk("s2_rerun_stop", rb, 0);
    chk("s2_rerun_done", dnb, 1);
    push3(1, 31, 0, 0);
    snap_read(1);

    // saturation and clear
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    ev = 2'b01;
    for (int i = 0; i < 20; i++) tick();
    ev = 2'b00;
    stop = 1'b1; tick(); stop = 1'b0;
    chk("s3_ovf", oc, 3'b011);
    chk("s3_done", dnc, 1);
    push3(2, 15, 15, 0);
    snap_read(2);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("s3_clr_ovf", oc, 0);
    chk("s3_clr_run", rc, 0);
    chk("s3_clr_done", dnc, 0);
    push3(2, 0, 0, 0);
    snap_read(2);

    // backpressure on every beat
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    ev = 2'b11;
    for (int i = 0; i < 4; i++) tick();
    ev = 2'b10; stop = 1'b1; tick();
    ev = 2'b00; stop = 1'b0;
    exd[0] = 5; exd[1] = 4; exd[2] = 5;
    push3(0, exd[0], exd[1], exd[2]);
    hs0 = hs_a;
    rd_ready = 1'b0;
    snap_a = 1'b1; tick(); snap_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 3; s++) begin
        if (k == 1 && s == 0) snap_a = 1'b1;
        chk("s4_hold_valid", va, 1);
        chk("s4_hold_idx", ia, k);
        chk("s4_hold_data", da, exd[k]);
        chk("s4_hold_last", la, (k == 2) ? 1 : 0);
        tick();
        snap_a = 1'b0;
      end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    end
    chk("s4_valid_off", va, 0);
    chk("s4_handshakes", hs_a - hs0, 3);
    chk("s4_q_empty", qa.size(), 0);

    // start+stop together, clear+start together
    do_reset();
    start = 1'b1; stop = 1'b1; tick();
    start = 1'b0; stop = 1'b0;
    chk("s5_idle_run", ra, 0);
    chk("s5_idle_done", dna, 0);
    push3(0, 0, 0, 0);
    snap_read(0);
    start = 1'b1; tick(); start = 1'b0;
    ev = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    chk("s5_running", ra, 1);
    clear = 1'b1; start = 1'b1; tick();
    clear = 1'b0; start = 1'b0; ev = 2'b00;
    chk("s5_clr_run", ra, 0);
    chk("s5_clr_done", dna, 0);
    chk("s5_clr_ovf", oa, 0);
    push3(0, 0, 0, 0);
    snap_read(0);

    // reset mid-stream and mid-run
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    ev = 2'b01;
    for (int i = 0; i < 20; i++) tick();
    rd_ready = 1'b0;
    snap_a = 1'b1; tick(); snap_a = 1'b0;
    tick();
    chk("s6_pre_valid", va, 1);
    chk("s6_pre_run", ra, 1);
    chk("s6_pre_ovf", oc, 3'b011);
    rst = 1'b1; tick(); rst = 1'b0; ev = 2'b00;
    chk("s6_valid", va, 0);
    chk("s6_run", ra, 0);
    chk("s6_ovf_a", oa, 0);
    chk("s6_ovf_c", oc, 0);
    chk("s6_data", da, 0);
    chk("s6_idx", ia, 0);
    push3(0, 0, 0, 0);
    push3(2, 0, 0, 0);
    rd_ready = 1'b1;
    snap_a = 1'b1; snap_c = 1'b1; tick();
    snap_a = 1'b0; snap_c = 1'b0;
    wait_q(0);
    wait_q(2);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
